// File: rtl/vds2431_mem_pkg.sv
// rtl/vds2431_mem_pkg.sv - shared function codes, select indices, dispatcher states and defaults
package vds2431_mem_pkg;

  localparam logic [7:0] CODE_WRITE_SCRATCH = 8'h0F;
  localparam logic [7:0] CODE_READ_SCRATCH  = 8'hAA;
  localparam logic [7:0] CODE_COPY_SCRATCH  = 8'h55;
  localparam logic [7:0] CODE_READ_MEMORY   = 8'hF0;

  localparam logic [1:0] SEL_WRITE_SCRATCH = 2'd0;
  localparam logic [1:0] SEL_READ_SCRATCH  = 2'd1;
  localparam logic [1:0] SEL_COPY_SCRATCH  = 2'd2;
  localparam logic [1:0] SEL_READ_MEMORY   = 2'd3;

  localparam logic [19:0] TIMEOUT_CYCLES_DEFAULT = 20'd600000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GETCMD = 3'd1,
    ST_DECODE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FINISH = 3'd4
  } dispState_t;

  // Returns {valid, sel}; unknown codes come back with valid = 0.
  function automatic logic [2:0] decodeCmd(input logic [7:0] code);
    case (code)
      CODE_WRITE_SCRATCH: decodeCmd = {1'b1, SEL_WRITE_SCRATCH};
      CODE_READ_SCRATCH:  decodeCmd = {1'b1, SEL_READ_SCRATCH};
      CODE_COPY_SCRATCH:  decodeCmd = {1'b1, SEL_COPY_SCRATCH};
      CODE_READ_MEMORY:   decodeCmd = {1'b1, SEL_READ_MEMORY};
      default:            decodeCmd = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/virtual_ds2431_mem_dispatch_pos_pulse.sv
// rtl/virtual_ds2431_mem_dispatch_pos_pulse.sv - posPulse: one-cycle pulse on a rising edge of a level input
module posPulse (
  input  logic clk,
  input  logic nRst,
  input  logic sig,
  output logic pulse
);

  logic sigQ;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) sigQ <= 1'b0;
    else       sigQ <= sig;
  end

  assign pulse = sig & ~sigQ;

endmodule

// File: rtl/virtual_ds2431_mem_dispatch.sv
// rtl/virtual_ds2431_mem_dispatch.sv - memory-function dispatcher sharing one byte transceiver
// Optional RUN watchdog: define VDS2431_MEM_DISPATCH_TIMEOUT_EN.
module virtual_ds2431_mem_dispatch
  import vds2431_mem_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       memCmdTrig,
  input  logic [7:0] receiveDat,
  input  logic       ByteTransDone,
  output logic       transTrig,
  output logic       nRxTx,
  output logic [3:0] subRunTrig,
  input  logic [3:0] subTransTrig,
  input  logic [3:0] subNRxTx,
  output logic [3:0] subByteDone,
  input  logic [3:0] subCmdDone,
  input  logic [3:0] subCmdFailed,
  output logic       busy,
  output logic       cmdDone,
  output logic       cmdFailed,
  output logic       cmdTimeout,
  output logic [7:0] cmdCode
);

  dispState_t state, nextState;
  logic [1:0] sel, nextSel;
  logic [1:0] settleCnt, nextSettleCnt;
  logic       abortPend, nextAbortPend;
  logic       nextBusy, nextDone, nextFailed;
  logic [7:0] nextCmdCode;
  logic       cmdPulse, bytePulse;
  logic [2:0] decoded;

  posPulse uCmdEdge  (.clk(clk), .nRst(nRst), .sig(memCmdTrig),    .pulse(cmdPulse));
  posPulse uByteEdge (.clk(clk), .nRst(nRst), .sig(ByteTransDone), .pulse(bytePulse));

  assign decoded = decodeCmd(cmdCode);

`ifdef VDS2431_MEM_DISPATCH_TIMEOUT_EN
  logic [19:0] wdCnt, nextWdCnt;
  logic        timeoutQ, nextTimeout;
  assign cmdTimeout = timeoutQ;
`else
  logic unusedTimeoutParam;
  assign unusedTimeoutParam = ^TIMEOUT_CYCLES;
  assign cmdTimeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= ST_IDLE;
      sel       <= 2'd0;
      settleCnt <= 2'd0;
      abortPend <= 1'b0;
      busy      <= 1'b0;
      cmdDone   <= 1'b0;
      cmdFailed <= 1'b0;
      cmdCode   <= 8'h00;
`ifdef VDS2431_MEM_DISPATCH_TIMEOUT_EN
      wdCnt     <= 20'd0;
      timeoutQ  <= 1'b0;
`endif
    end else begin
      state     <= nextState;
      sel       <= nextSel;
      settleCnt <= nextSettleCnt;
      abortPend <= nextAbortPend;
      busy      <= nextBusy;
      cmdDone   <= nextDone;
      cmdFailed <= nextFailed;
      cmdCode   <= nextCmdCode;
`ifdef VDS2431_MEM_DISPATCH_TIMEOUT_EN
      wdCnt     <= nextWdCnt;
      timeoutQ  <= nextTimeout;
`endif
    end
  end

  always_comb begin
    nextState     = state;
    nextSel       = sel;
    nextSettleCnt = settleCnt;
    nextAbortPend = abortPend;
    nextBusy      = busy;
    nextDone      = cmdDone;
    nextFailed    = cmdFailed;
    nextCmdCode   = cmdCode;
`ifdef VDS2431_MEM_DISPATCH_TIMEOUT_EN
    nextWdCnt     = wdCnt;
    nextTimeout   = timeoutQ;
`endif
    transTrig     = 1'b0;
    nRxTx         = 1'b0;
    subRunTrig    = 4'b0000;
    subByteDone   = 4'b0000;

    if (state == ST_RUN) begin
      subRunTrig  = 4'b0001 << sel;
      subByteDone = {4{ByteTransDone}} & (4'b0001 << sel);
      transTrig   = subTransTrig[sel];
      nRxTx       = subNRxTx[sel];
    end else if (state == ST_GETCMD) begin
      transTrig   = 1'b1;
    end

    // An abort parks in IDLE for one cycle so every run trigger drops before GETCMD.
    if (cmdPulse && state != ST_IDLE) begin
      nextState     = ST_IDLE;
      nextAbortPend = 1'b1;
      nextBusy      = 1'b1;
      nextDone      = 1'b0;
      nextFailed    = 1'b0;
      nextCmdCode   = 8'h00;
`ifdef VDS2431_MEM_DISPATCH_TIMEOUT_EN
      nextTimeout   = 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmdPulse || abortPend) begin
            nextState     = ST_GETCMD;
            nextAbortPend = 1'b0;
            nextBusy      = 1'b1;
            nextDone      = 1'b0;
            nextFailed    = 1'b0;
            nextCmdCode   = 8'h00;
`ifdef VDS2431_MEM_DISPATCH_TIMEOUT_EN
            nextTimeout   = 1'b0;
`endif
          end
        end
        ST_GETCMD: begin
          if (bytePulse) begin
            nextCmdCode = receiveDat;
            nextState   = ST_DECODE;
          end
        end
        ST_DECODE: begin
          nextSettleCnt = 2'd0;
`ifdef VDS2431_MEM_DISPATCH_TIMEOUT_EN
          nextWdCnt     = 20'd0;
`endif
          if (decoded[2]) begin
            nextSel   = decoded[1:0];
            nextState = ST_RUN;
          end else begin
            nextState  = ST_FINISH;
            nextFailed = 1'b1;
            nextBusy   = 1'b0;
          end
        end
        ST_RUN: begin
`ifdef VDS2431_MEM_DISPATCH_TIMEOUT_EN
          nextWdCnt = wdCnt + 20'd1;
`endif
          // The first two RUN cycles cover the selected function's reset latency.
          if (settleCnt != 2'd2) begin
            nextSettleCnt = settleCnt + 2'd1;
          end else if (subCmdFailed[sel]) begin
            nextState  = ST_FINISH;
            nextFailed = 1'b1;
            nextBusy   = 1'b0;
          end else if (subCmdDone[sel]) begin
            nextState  = ST_FINISH;
            nextDone   = 1'b1;
            nextBusy   = 1'b0;
          end
`ifdef VDS2431_MEM_DISPATCH_TIMEOUT_EN
          if (nextState == ST_RUN && wdCnt == TIMEOUT_CYCLES - 20'd1) begin
            nextState   = ST_FINISH;
            nextFailed  = 1'b1;
            nextTimeout = 1'b1;
            nextBusy    = 1'b0;
          end
`endif
        end
        ST_FINISH: begin
          nextState = ST_IDLE;
          nextBusy  = 1'b0;
        end
        default: begin
          nextState = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_virtual_ds2431_mem_dispatch.sv
// tb/tb_virtual_ds2431_mem_dispatch.sv - directed-vector bench for virtual_ds2431_mem_dispatch
`timescale 1ns/1ps
module tb_virtual_ds2431_mem_dispatch;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       memCmdTrig = 1'b0;
  logic [7:0] receiveDat = 8'h00;
  logic       ByteTransDone = 1'b0;
  logic       transTrig, nRxTx;
  logic [3:0] subRunTrig, subByteDone;
  logic [3:0] subTransTrig = 4'b0000;
  logic [3:0] subNRxTx = 4'b0000;
  logic [3:0] subCmdDone = 4'b0000;
  logic [3:0] subCmdFailed = 4'b0000;
  logic       busy, cmdDone, cmdFailed, cmdTimeout;
  logic [7:0] cmdCode;

  int nVec = 0;
  int nErr = 0;

  virtual_ds2431_mem_dispatch #(.TIMEOUT_CYCLES(20'd100)) dut (
    .clk(clk), .nRst(nRst), .memCmdTrig(memCmdTrig), .receiveDat(receiveDat),
    .ByteTransDone(ByteTransDone), .transTrig(transTrig), .nRxTx(nRxTx),
    .subRunTrig(subRunTrig), .subTransTrig(subTransTrig), .subNRxTx(subNRxTx),
    .subByteDone(subByteDone), .subCmdDone(subCmdDone), .subCmdFailed(subCmdFailed),
    .busy(busy), .cmdDone(cmdDone), .cmdFailed(cmdFailed), .cmdTimeout(cmdTimeout),
    .cmdCode(cmdCode)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge on memCmdTrig, deliver one byte, and land in the cycle after DECODE.
  task automatic startCmd(input logic [7:0] b);
    memCmdTrig = 1'b1;
    step();
    memCmdTrig = 1'b0;
    receiveDat = b;
    ByteTransDone = 1'b1;
    step();
    ByteTransDone = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #3;
    nVec++; if ({transTrig, nRxTx, subRunTrig, subByteDone} !== 10'd0) begin nErr++; $display("FAIL reset_trans: got %b want 0", {transTrig, nRxTx, subRunTrig, subByteDone}); end
    nVec++; if ({busy, cmdDone, cmdFailed, cmdTimeout, cmdCode} !== 12'd0) begin nErr++; $display("FAIL reset_status: got %h want 0", {busy, cmdDone, cmdFailed, cmdTimeout, cmdCode}); end
    step();
    step();
    nRst = 1'b1;
    step();
    nVec++; if ({busy, transTrig} !== 2'b00) begin nErr++; $display("FAIL idle_after_reset: got %b want 00", {busy, transTrig}); end
  endtask

  task automatic test_copy_done();
    memCmdTrig = 1'b1;
    step();
    memCmdTrig = 1'b0;
    #1;
    nVec++; if ({busy, transTrig, nRxTx} !== 3'b110) begin nErr++; $display("FAIL getcmd_out: got %b want 110", {busy, transTrig, nRxTx}); end
    receiveDat = 8'h55;
    ByteTransDone = 1'b1;
    step();
    ByteTransDone = 1'b0;
    nVec++; if (cmdCode !== 8'h55) begin nErr++; $display("FAIL latch_code: got %h want 55", cmdCode); end
    nVec++; if (transTrig !== 1'b0) begin nErr++; $display("FAIL decode_trans: got %b want 0", transTrig); end
    step();
    nVec++; if (subRunTrig !== 4'b0100) begin nErr++; $display("FAIL copy_run: got %b want 0100", subRunTrig); end
    repeat (5) step();
    subCmdDone = 4'b0100;
    #1;
    nVec++; if (cmdDone !== 1'b0) begin nErr++; $display("FAIL copy_done_early: got %b want 0", cmdDone); end
    step();
    subCmdDone = 4'b0000;
    nVec++; if ({cmdDone, cmdFailed, busy, subRunTrig} !== 7'b1000000) begin nErr++; $display("FAIL copy_finish: got %b want 1000000", {cmdDone, cmdFailed, busy, subRunTrig}); end
    step();
    nVec++; if (cmdDone !== 1'b1) begin nErr++; $display("FAIL copy_done_hold: got %b want 1", cmdDone); end
  endtask

  task automatic test_bad_code();
    logic seenRun;
    seenRun = 1'b0;
    memCmdTrig = 1'b1;
    step();
    memCmdTrig = 1'b0;
    nVec++; if ({cmdDone, cmdCode} !== 9'd0) begin nErr++; $display("FAIL flags_cleared: got %h want 0", {cmdDone, cmdCode}); end
    receiveDat = 8'h3C;
    ByteTransDone = 1'b1;
    step();
    ByteTransDone = 1'b0;
    if (subRunTrig !== 4'b0000) seenRun = 1'b1;
    step();
    if (subRunTrig !== 4'b0000) seenRun = 1'b1;
    nVec++; if ({cmdFailed, cmdDone, busy} !== 3'b100) begin nErr++; $display("FAIL bad_code_flags: got %b want 100", {cmdFailed, cmdDone, busy}); end
    step();
    if (subRunTrig !== 4'b0000) seenRun = 1'b1;
    nVec++; if (seenRun !== 1'b0) begin nErr++; $display("FAIL bad_code_run: got %b want 0", seenRun); end
  endtask

  task automatic test_settle_and_both();
    startCmd(8'h0F);
    subCmdDone = 4'b0001;
    step();
    step();
    subCmdDone = 4'b0000;
    nVec++; if ({subRunTrig, cmdDone} !== 5'b00010) begin nErr++; $display("FAIL settle_ignore: got %b want 00010", {subRunTrig, cmdDone}); end
    subCmdDone = 4'b0001;
    step();
    subCmdDone = 4'b0000;
    nVec++; if ({cmdDone, subRunTrig} !== 5'b10000) begin nErr++; $display("FAIL settle_done: got %b want 10000", {cmdDone, subRunTrig}); end
    step();
    startCmd(8'hF0);
    nVec++; if (subRunTrig !== 4'b1000) begin nErr++; $display("FAIL readmem_run: got %b want 1000", subRunTrig); end
    repeat (3) step();
    subCmdDone = 4'b1000;
    subCmdFailed = 4'b1000;
    step();
    subCmdDone = 4'b0000;
    subCmdFailed = 4'b0000;
    nVec++; if ({cmdFailed, cmdDone} !== 2'b10) begin nErr++; $display("FAIL both_flags: got %b want 10", {cmdFailed, cmdDone}); end
    step();
  endtask

  task automatic test_mux_and_abort();
    startCmd(8'hAA);
    nVec++; if (subRunTrig !== 4'b0010) begin nErr++; $display("FAIL readsp_run: got %b want 0010", subRunTrig); end
    subTransTrig = 4'b0010;
    subNRxTx = 4'b0010;
    ByteTransDone = 1'b1;
    #1;
    nVec++; if ({transTrig, nRxTx, subByteDone} !== 6'b110010) begin nErr++; $display("FAIL mux_sel1: got %b want 110010", {transTrig, nRxTx, subByteDone}); end
    subTransTrig = 4'b1101;
    subNRxTx = 4'b1101;
    ByteTransDone = 1'b0;
    #1;
    nVec++; if ({transTrig, nRxTx, subByteDone} !== 6'b000000) begin nErr++; $display("FAIL mux_other: got %b want 000000", {transTrig, nRxTx, subByteDone}); end
    subTransTrig = 4'b0000;
    subNRxTx = 4'b0000;
    memCmdTrig = 1'b1;
    step();
    memCmdTrig = 1'b0;
    nVec++; if ({subRunTrig, busy, cmdCode} !== 13'b0000_1_00000000) begin nErr++; $display("FAIL abort_gap: got %b want 0000100000000", {subRunTrig, busy, cmdCode}); end
    step();
    nVec++; if ({transTrig, subRunTrig, busy, cmdCode} !== 14'b1_0000_1_00000000) begin nErr++; $display("FAIL abort_getcmd: got %b want 10000100000000", {transTrig, subRunTrig, busy, cmdCode}); end
    receiveDat = 8'h0F;
    ByteTransDone = 1'b1;
    step();
    ByteTransDone = 1'b0;
    step();
    nVec++; if (subRunTrig !== 4'b0001) begin nErr++; $display("FAIL abort_resume: got %b want 0001", subRunTrig); end
  endtask

  task automatic test_reset_mid_run();
    step();
    step();
    nRst = 1'b0;
    #1;
    nVec++; if ({transTrig, nRxTx, subRunTrig, subByteDone, busy, cmdDone, cmdFailed, cmdTimeout, cmdCode} !== 22'd0) begin nErr++; $display("FAIL reset_mid_run: got %h want 0", {transTrig, nRxTx, subRunTrig, subByteDone, busy, cmdDone, cmdFailed, cmdTimeout, cmdCode}); end
    step();
    nRst = 1'b1;
    step();
    step();
    nVec++; if ({busy, cmdDone, cmdFailed, subRunTrig} !== 7'd0) begin nErr++; $display("FAIL after_reset: got %b want 0", {busy, cmdDone, cmdFailed, subRunTrig}); end
  endtask

  task automatic test_timeout();
    startCmd(8'h55);
`ifdef VDS2431_MEM_DISPATCH_TIMEOUT_EN
    repeat (99) step();
    nVec++; if ({busy, cmdTimeout} !== 2'b10) begin nErr++; $display("FAIL timeout_early: got %b want 10", {busy, cmdTimeout}); end
    step();
    nVec++; if ({cmdTimeout, cmdFailed, cmdDone, busy} !== 4'b1100) begin nErr++; $display("FAIL timeout_hit: got %b want 1100", {cmdTimeout, cmdFailed, cmdDone, busy}); end
`else
    repeat (150) step();
    nVec++; if ({busy, cmdTimeout, cmdFailed, subRunTrig} !== 7'b1000100) begin nErr++; $display("FAIL no_watchdog: got %b want 1000100", {busy, cmdTimeout, cmdFailed, subRunTrig}); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_copy_done();
    test_bad_code();
    test_settle_and_both();
    test_mux_and_abort();
    test_reset_mid_run();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/virtual_ds2431_mem_dispatch.md
VIRTUAL_DS2431_MEM_DISPATCH -- requirements
Module: virtual_ds2431_mem_dispatch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20'd600000, SHALL set the RUN-state watchdog limit in clk cycles (used only when the watchdog is compiled in).
REQ-002 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 nRst  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 memCmdTrig  in  1  SHALL start a memory-function phase on its rising edge (issued by the ROM layer).
REQ-005 receiveDat  in  8  SHALL carry the last byte received by the shared byte transceiver.
REQ-006 ByteTransDone  in  1  SHALL be the transceiver byte-complete flag (level; rising edge significant).
REQ-007 transTrig / nRxTx  out  1 / 1  SHALL drive the shared transceiver request and direction (0 = receive, 1 = transmit).
REQ-008 subRunTrig  out  4  SHALL be the per-function run triggers: [0] WriteScratchpad, [1] ReadScratchpad, [2] CopyScratchpad, [3] ReadMemory.
REQ-009 subTransTrig / subNRxTx  in  4 / 4  SHALL be the per-function transceiver requests and directions.
REQ-010 subByteDone  out  4  SHALL be ByteTransDone routed to the selected function only.
REQ-011 subCmdDone / subCmdFailed  in  4 / 4  SHALL be the per-function completion flags.
REQ-012 busy, cmdDone, cmdFailed, cmdTimeout  out  1 each  SHALL be the phase status flags.
REQ-013 cmdCode  out  8  SHALL hold the latched function byte.

Function
REQ-014 The block SHALL detect rising edges of memCmdTrig and ByteTransDone with posPulse instances; each edge is a one-cycle pulse.
REQ-015 States: IDLE, GETCMD, DECODE, RUN, FINISH; the encoding is internal.
REQ-016 IDLE -> GETCMD on a memCmdTrig edge; cmdDone, cmdFailed, cmdTimeout and cmdCode are cleared and busy is set in the same cycle.
REQ-017 GETCMD: transTrig = 1 and nRxTx = 0 until a ByteTransDone edge; on that edge, cmdCode <= receiveDat, transTrig <= 0, and the state advances to DECODE.
REQ-018 DECODE (1 cycle): cmdCode is mapped 0x0F->0, 0xAA->1, 0x55->2, 0xF0->3 into a 2-bit sel, and the state advances to RUN; any other code -> FINISH with cmdFailed = 1.
REQ-019 RUN: subRunTrig[sel] = 1 and all other bits = 0; transTrig = subTransTrig[sel]; nRxTx = subNRxTx[sel]; subByteDone = ByteTransDone only on bit sel.
REQ-020 RUN: subCmdDone and subCmdFailed SHALL be ignored during the first 2 RUN cycles, covering the function reset latency.
REQ-021 RUN exit: subCmdFailed[sel] -> FINISH with cmdFailed = 1; otherwise subCmdDone[sel] -> FINISH with cmdDone = 1. If both flags are high in the same cycle, failed wins.
REQ-022 FINISH: subRunTrig = 0, transTrig = 0, busy = 0; cmdDone and cmdFailed hold until the next memCmdTrig edge; the state advances to IDLE the next cycle.
REQ-023 A memCmdTrig edge in any non-IDLE state SHALL abort: all subRunTrig are driven low for one cycle, then the block re-enters GETCMD with flags cleared.
REQ-024 Outside RUN, transTrig and nRxTx SHALL come only from the dispatcher and subByteDone SHALL be 0.
REQ-025 Latency: a subCmdDone[sel] rise becomes cmdDone = 1 exactly 1 cycle later.

Reset
REQ-026 On nRst low, all outputs SHALL be 0 and the state SHALL be IDLE, independent of clk; a reset in the middle of an operation abandons it with no completion flag.

Configuration
REQ-027 With VDS2431_MEM_DISPATCH_TIMEOUT_EN defined, a 20-bit counter SHALL count RUN cycles; reaching TIMEOUT_CYCLES -> FINISH with cmdFailed = 1 and cmdTimeout = 1. The counter clears on entering RUN.
REQ-028 Without VDS2431_MEM_DISPATCH_TIMEOUT_EN, no counter is present, RUN waits indefinitely, and cmdTimeout is tied to 0.

Structure
REQ-029 The function codes (0x0F, 0xAA, 0x55, 0xF0), the sel indices, the state encodings and the TIMEOUT_CYCLES default SHALL live in a shared package/include, vds2431_mem_pkg.
REQ-030 The only sub-module SHALL be posPulse, instanced twice; the output multiplexing SHALL be inline.

Verification
REQ-031 memCmdTrig edge, byte 0x55, subCmdDone[2] rises 5 cycles into RUN -> subRunTrig = 4'b0100 and cmdDone = 1 one cycle after the rise.
REQ-032 Byte 0x3C -> cmdFailed = 1 and subRunTrig never nonzero.
REQ-033 Byte 0xF0, with subCmdDone[3] and subCmdFailed[3] rising together -> cmdFailed = 1 and cmdDone = 0.
REQ-034 In RUN with sel = 1, toggling subTransTrig = 4'b0010 and ByteTransDone -> transTrig follows and subByteDone = 4'b0010 only.
REQ-035 Second memCmdTrig edge during RUN -> subRunTrig low for 1 cycle, then the block is in GETCMD with cmdCode = 0.
REQ-036 With the macro defined and TIMEOUT_CYCLES = 100, no subCmdDone -> cmdTimeout = 1 after 100 RUN cycles; nRst pulse mid-RUN -> all outputs 0.
